// File: rtl/flash_bus_ctrl_if.sv
// Host-side byte interface of the flash/SRAM bus controller.
interface flash_bus_if #(
  parameter int DW = 8
);
  logic          wr_addr;
  logic          wr_data;
  logic          rd_data;
  logic [DW-1:0] wr_buffer;
  logic          autoinc_ena;
  logic          poll_ena;
  logic [DW-1:0] rd_buffer;
  logic          busy;
  logic          done;
  logic          timeout;

  modport master (
    output wr_addr, wr_data, rd_data, wr_buffer, autoinc_ena, poll_ena,
    input  rd_buffer, busy, done, timeout
  );

  modport slave (
    input  wr_addr, wr_data, rd_data, wr_buffer, autoinc_ena, poll_ena,
    output rd_buffer, busy, done, timeout
  );
endinterface

// File: rtl/flash_bus_ctrl.sv
// Parallel flash/SRAM bus controller: multi-byte address load, timed read/write
// cycles with optional auto-increment and JEDEC DQ7 data polling after writes.
module flash_bus_ctrl #(
  parameter int AW       = 19,
  parameter int DW       = 8,
  parameter int TSU      = 1,
  parameter int TPW      = 4,
  parameter int THD      = 1,
  parameter int POLL_MAX = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  flash_bus_if.slave    host,
  output logic [AW-1:0] rom_a,
  inout  wire  [DW-1:0] rom_d,
  output logic          rom_cs_n,
  output logic          rom_oe_n,
  output logic          rom_we_n
);
  localparam int NAB  = (AW + 7) / 8;
  localparam int PHW  = (NAB > 1) ? $clog2(NAB) : 1;
  localparam int TMAX = (TSU > TPW) ? ((TSU > THD) ? TSU : THD)
                                    : ((TPW > THD) ? TPW : THD);
  localparam int CW   = $clog2(TMAX + 1);
  localparam int PCW  = $clog2(POLL_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PCW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   next_addr_q, next_addr_d;
  logic [PHW-1:0]  phase_q, phase_d;
  logic            rnw_q, rnw_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            poll_q, poll_d;
  logic [DW-1:0]   rd_buffer_q, rd_buffer_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            cs_n_q, cs_n_d;
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;
  logic            drive_q, drive_d;
  logic            a_en_q, a_en_d;

  logic            single_cmd;
  logic            phase_last;
  logic [7:0]      abyte;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    poll_cnt_d  = poll_cnt_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    phase_d     = phase_q;
    rnw_d       = rnw_q;
    wdata_d     = wdata_q;
    poll_d      = poll_q;
    rd_buffer_d = rd_buffer_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    a_en_d      = 1'b1;
    abyte       = host.wr_buffer[7:0];
    phase_last  = (phase_q == PHW'(NAB - 1));
    single_cmd  = ({host.wr_addr, host.wr_data, host.rd_data} == 3'b100) ||
                  ({host.wr_addr, host.wr_data, host.rd_data} == 3'b010) ||
                  ({host.wr_addr, host.wr_data, host.rd_data} == 3'b001);

    case (state_q)
      S_IDLE: begin
        if (single_cmd && host.wr_addr) begin
          // Bits of the top byte beyond AW simply have no destination bit.
          for (int unsigned b = 0; b < AW; b++) begin
            if ((b >> 3) == 32'(phase_q)) next_addr_d[b] = abyte[b[2:0]];
          end
          phase_d = phase_last ? '0 : phase_q + 1'b1;
        end else if (single_cmd) begin
          addr_d     = next_addr_q;
          rnw_d      = host.rd_data;
          wdata_d    = host.wr_buffer;
          poll_d     = host.poll_ena & host.wr_data;
          timeout_d  = 1'b0;
          phase_d    = '0;
          cnt_d      = '0;
          poll_cnt_d = '0;
          state_d    = S_SETUP;
          if (host.autoinc_ena) next_addr_d = next_addr_q + 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(TSU - 1)) begin
          cnt_d   = '0;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == CW'(TPW - 1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
          if (rnw_q) rd_buffer_d = rom_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(THD - 1)) begin
          cnt_d = '0;
          if (!poll_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (!rnw_q) begin
            // Polled write turns into read cycles at the same address.
            rnw_d   = 1'b1;
            state_d = S_SETUP;
          end else if (rd_buffer_q[7] == wdata_q[7]) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (poll_cnt_q == PCW'(POLL_MAX - 1)) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            state_d    = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin controls are registered from the upcoming state so they change with it.
    cs_n_d  = (state_d == S_IDLE);
    oe_n_d  = !((state_d == S_STROBE) && rnw_d);
    we_n_d  = !((state_d == S_STROBE) && !rnw_d);
    drive_d = (state_d != S_IDLE) && !rnw_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      poll_cnt_q  <= '0;
      addr_q      <= '0;
      next_addr_q <= '0;
      phase_q     <= '0;
      rnw_q       <= 1'b1;
      wdata_q     <= '0;
      poll_q      <= 1'b0;
      rd_buffer_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      a_en_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      phase_q     <= phase_d;
      rnw_q       <= rnw_d;
      wdata_q     <= wdata_d;
      poll_q      <= poll_d;
      rd_buffer_q <= rd_buffer_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cs_n_q      <= cs_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      drive_q     <= drive_d;
      a_en_q      <= a_en_d;
    end
  end

  assign rom_a    = a_en_q ? addr_q : 'z;
  assign rom_d    = drive_q ? wdata_q : 'z;
  assign rom_cs_n = cs_n_q;
  assign rom_oe_n = oe_n_q;
  assign rom_we_n = we_n_q;

  assign host.rd_buffer = rd_buffer_q;
  assign host.busy      = (state_q != S_IDLE);
  assign host.done      = done_q;
  assign host.timeout   = timeout_q;
endmodule

// File: tb/tb_flash_bus_ctrl.sv
// Bench for flash_bus_ctrl: vector table, hand sequences for polling/reset,
// then random commands against a transaction-level model.
module tb_flash_bus_ctrl;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int TSU = 1;
  localparam int TPW = 4;
  localparam int THD = 1;
  localparam int PMAX = 4;
  localparam int L = TSU + TPW + THD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flash_bus_if #(.DW(DW)) bus ();
  wire [AW-1:0] rom_a;
  wire [DW-1:0] rom_d;
  logic rom_cs_n, rom_oe_n, rom_we_n;

  flash_bus_ctrl #(.AW(AW), .DW(DW), .TSU(TSU), .TPW(TPW), .THD(THD), .POLL_MAX(PMAX)) dut (
    .clk(clk), .rst_n(rst_n), .host(bus), .rom_a(rom_a), .rom_d(rom_d),
    .rom_cs_n(rom_cs_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n)
  );

  // Undriven pins float high, so a released bus reads as all ones.
  for (genvar i = 0; i < DW; i++) begin : g_pd
    pullup (rom_d[i]);
  end
  for (genvar i = 0; i < AW; i++) begin : g_pa
    pullup (rom_a[i]);
  end

  // Memory model: plain reads return rd_val, poll reads walk poll_resp.
  logic [7:0] rd_val;
  bit         poll_mode;
  logic [7:0] poll_resp [0:7];
  int         poll_idx;
  logic [7:0] mem_out;
  always_comb mem_out = poll_mode ? poll_resp[poll_idx[2:0]] : rd_val;
  assign rom_d = (!rom_cs_n && !rom_oe_n) ? mem_out : 'z;
  always @(posedge rom_oe_n) if (poll_mode) poll_idx = poll_idx + 1;

  int total = 0;
  int bad = 0;

  logic [18:0] m_next;
  int          m_phase;
  logic [7:0]  m_rb;
  bit          m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Number of poll reads and timeout implied by the response list.
  task automatic poll_model(input logic [7:0] w, output int k, output bit to);
    bit hit;
    hit = 1'b0;
    k = 0;
    for (int i = 0; i < PMAX; i++) begin
      if (!hit) begin
        k = i + 1;
        if (poll_resp[i][7] == w[7]) hit = 1'b1;
      end
    end
    to = !hit;
  endtask

  // kind: 0 wr_addr, 1 rd, 2 wr, 3 wr_addr+rd, 4 wr_data+rd
  task automatic run_cmd(input int kind, input logic [7:0] d, input bit ai, input bit pe,
                         input logic [18:0] exp_a, input logic [7:0] exp_rb,
                         input int k, input bit exp_to, input string tag);
    int guard, cyc, seg, p, seg_err, a_err, d_err;
    bit rd_seg, exp_oe, exp_we;
    logic [7:0] exp_d;
    guard = 0;
    while (bus.busy !== 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, {31'b0, bus.busy}, 32'd0);
    bus.wr_buffer   = d;
    bus.autoinc_ena = ai;
    bus.poll_ena    = pe;
    bus.wr_addr     = (kind == 0 || kind == 3);
    bus.rd_data     = (kind == 1 || kind == 3 || kind == 4);
    bus.wr_data     = (kind == 2 || kind == 4);
    @(negedge clk);
    bus.wr_addr = 1'b0;
    bus.rd_data = 1'b0;
    bus.wr_data = 1'b0;
    if (kind == 0 || kind == 3 || kind == 4) begin
      check({tag, "_nobusy"}, {31'b0, bus.busy}, 32'd0);
      check({tag, "_to"}, {31'b0, bus.timeout}, {31'b0, exp_to});
      return;
    end
    cyc = 0; seg_err = 0; a_err = 0; d_err = 0;
    while (bus.busy === 1'b1 && cyc < 300) begin
      seg = cyc / L;
      p = cyc % L;
      rd_seg = (seg > 0) || (kind == 1);
      exp_oe = !(rd_seg && p >= TSU && p < TSU + TPW);
      exp_we = !(!rd_seg && p >= TSU && p < TSU + TPW);
      if (rom_cs_n !== 1'b0 || rom_oe_n !== exp_oe || rom_we_n !== exp_we) seg_err++;
      if (rom_a !== exp_a) a_err++;
      if (!rd_seg) exp_d = d;
      else if (p >= TSU && p < TSU + TPW) exp_d = (seg == 0) ? rd_val : poll_resp[seg-1];
      else exp_d = 8'hFF;
      if (rom_d !== exp_d) d_err++;
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busycyc"}, cyc, (1 + k) * L);
    check({tag, "_done"}, {31'b0, bus.done}, 32'd1);
    check({tag, "_rdbuf"}, {24'b0, bus.rd_buffer}, {24'b0, exp_rb});
    check({tag, "_to"}, {31'b0, bus.timeout}, {31'b0, exp_to});
    check({tag, "_strobes"}, seg_err, 0);
    check({tag, "_addr"}, a_err, 0);
    check({tag, "_data"}, d_err, 0);
    check({tag, "_idle_pins"}, {22'b0, rom_cs_n, rom_d, rom_oe_n}, {22'b0, 1'b1, 8'hFF, 1'b1});
  endtask

  task automatic do_op(input int kind, input logic [7:0] d, input bit ai, input bit pe, input string tag);
    int k;
    bit to;
    logic [18:0] a;
    logic [23:0] t;
    k = 0;
    to = 1'b0;
    if (kind == 0) begin
      t = {5'b0, m_next};
      t = (t & ~(24'hFF << (8 * m_phase))) | (24'(d) << (8 * m_phase));
      m_next = t[18:0];
      m_phase = (m_phase + 1) % 3;
      run_cmd(0, d, ai, pe, 19'h0, m_rb, 0, m_to, tag);
    end else if (kind >= 3) begin
      run_cmd(kind, d, ai, pe, 19'h0, m_rb, 0, m_to, tag);
    end else begin
      a = m_next;
      if (ai) m_next = m_next + 19'd1;
      m_phase = 0;
      if (kind == 2 && pe) begin
        poll_idx = 0;
        poll_mode = 1'b1;
        poll_model(d, k, to);
      end
      if (kind == 1) m_rb = rd_val;
      else if (k > 0) m_rb = poll_resp[k-1];
      m_to = to;
      run_cmd(kind, d, ai, pe, a, m_rb, k, to, tag);
      poll_mode = 1'b0;
    end
  endtask

  typedef struct {
    int          kind;
    logic [7:0]  d;
    bit          ai;
    logic [7:0]  rdv;
    logic [18:0] exp_a;
    logic [7:0]  exp_rb;
  } vec_t;
  vec_t vecs [14];

  initial begin
    int g, cyc, r, kind;
    bus.wr_addr = 1'b0; bus.wr_data = 1'b0; bus.rd_data = 1'b0;
    bus.wr_buffer = '0; bus.autoinc_ena = 1'b0; bus.poll_ena = 1'b0;
    rd_val = 8'h00; poll_mode = 1'b0; poll_idx = 0;
    for (int i = 0; i < 8; i++) poll_resp[i] = 8'h00;

    vecs[0]  = '{0, 8'h34, 1'b0, 8'h00, 19'h00000, 8'h00};
    vecs[1]  = '{0, 8'h12, 1'b0, 8'h00, 19'h00000, 8'h00};
    vecs[2]  = '{0, 8'hFF, 1'b0, 8'h00, 19'h00000, 8'h00};
    vecs[3]  = '{1, 8'h00, 1'b0, 8'hA5, 19'h71234, 8'hA5};
    vecs[4]  = '{2, 8'h11, 1'b1, 8'h00, 19'h71234, 8'hA5};
    vecs[5]  = '{2, 8'h22, 1'b1, 8'h00, 19'h71235, 8'hA5};
    vecs[6]  = '{2, 8'h33, 1'b1, 8'h00, 19'h71236, 8'hA5};
    vecs[7]  = '{3, 8'h00, 1'b0, 8'h00, 19'h00000, 8'hA5};
    vecs[8]  = '{0, 8'hFF, 1'b0, 8'h00, 19'h00000, 8'hA5};
    vecs[9]  = '{0, 8'hFF, 1'b0, 8'h00, 19'h00000, 8'hA5};
    vecs[10] = '{0, 8'hFF, 1'b0, 8'h00, 19'h00000, 8'hA5};
    vecs[11] = '{1, 8'h00, 1'b1, 8'h3C, 19'h7FFFF, 8'h3C};
    vecs[12] = '{1, 8'h00, 1'b1, 8'hC3, 19'h00000, 8'hC3};
    vecs[13] = '{1, 8'h00, 1'b0, 8'h5A, 19'h00001, 8'h5A};

    // Reset state, including floating address and data pins.
    #12;
    check("rst_pins", {28'b0, rom_cs_n, rom_oe_n, rom_we_n, bus.busy}, 32'b1110);
    check("rst_flags", {30'b0, bus.done, bus.timeout}, 32'd0);
    check("rst_rdbuf", {24'b0, bus.rd_buffer}, 32'd0);
    check("rst_rom_a_z", {13'b0, rom_a}, 32'h7FFFF);
    check("rst_rom_d_z", {24'b0, rom_d}, 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rom_a_after_rst", {13'b0, rom_a}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      rd_val = vecs[i].rdv;
      run_cmd(vecs[i].kind, vecs[i].d, vecs[i].ai, 1'b0, vecs[i].exp_a, vecs[i].exp_rb,
              0, 1'b0, $sformatf("vec%0d", i));
    end
    m_next = 19'h00001; m_phase = 0; m_rb = 8'h5A; m_to = 1'b0;

    // Commands during busy must be ignored.
    rd_val = 8'h66;
    bus.autoinc_ena = 1'b1; bus.rd_data = 1'b1;
    @(negedge clk);
    bus.rd_data = 1'b1;
    @(negedge clk);
    bus.rd_data = 1'b0; bus.wr_addr = 1'b1; bus.wr_buffer = 8'h55;
    @(negedge clk);
    bus.wr_addr = 1'b0;
    cyc = 3;
    while (bus.busy === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_ign_cyc", cyc, L + 1);
    check("busy_ign_rdbuf", {24'b0, bus.rd_buffer}, 32'h66);
    check("busy_ign_done", {31'b0, bus.done}, 32'd1);
    @(negedge clk);
    check("done_pulse_1cyc", {31'b0, bus.done}, 32'd0);
    m_next = 19'h00002; m_rb = 8'h66;
    rd_val = 8'h77;
    do_op(1, 8'h00, 1'b0, 1'b0, "busy_ign_next");

    // DQ7 polling: success on 4th read, timeout, immediate success.
    poll_resp[0] = 8'h00; poll_resp[1] = 8'h00; poll_resp[2] = 8'h00; poll_resp[3] = 8'h80;
    do_op(2, 8'h80, 1'b0, 1'b1, "poll_ok4");
    for (int i = 0; i < 8; i++) poll_resp[i] = 8'h00;
    do_op(2, 8'h80, 1'b0, 1'b1, "poll_timeout");
    do_op(0, 8'h9A, 1'b0, 1'b0, "to_sticky");
    poll_resp[0] = 8'h7F;
    do_op(2, 8'h01, 1'b1, 1'b1, "poll_ok1");

    // Reset in the middle of a write strobe.
    g = 0;
    while (bus.busy !== 1'b0 && g < 100) begin @(negedge clk); g++; end
    bus.wr_buffer = 8'h5C; bus.wr_data = 1'b1;
    @(negedge clk);
    bus.wr_data = 1'b0;
    g = 0;
    while (rom_we_n !== 1'b0 && g < 20) begin @(negedge clk); g++; end
    check("mid_we_low", {31'b0, rom_we_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {29'b0, rom_cs_n, rom_oe_n, rom_we_n}, 32'b111);
    check("mid_rst_rom_d", {24'b0, rom_d}, 32'hFF);
    check("mid_rst_rom_a", {13'b0, rom_a}, 32'h7FFFF);
    check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_rom_a_still_z", {13'b0, rom_a}, 32'h7FFFF);
    @(negedge clk);
    check("rel_rom_a", {13'b0, rom_a}, 32'h0);
    check("rel_rdbuf", {24'b0, bus.rd_buffer}, 32'h0);
    m_next = '0; m_phase = 0; m_rb = 8'h00; m_to = 1'b0;

    // Random commands against the model.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) kind = 0;
      else if (r == 3) kind = 3 + $urandom_range(0, 1);
      else if (r < 7) kind = 1;
      else kind = 2;
      rd_val = 8'($urandom);
      for (int j = 0; j < 8; j++) poll_resp[j] = 8'($urandom);
      do_op(kind, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flash_bus_ctrl.md
# flash_bus_ctrl

Parametrised parallel flash/SRAM bus controller for the NeoGS flash programmer. It sits between the host-side byte interface and the external memory pins. It loads a multi-byte address, runs single read/write cycles with programmable setup, strobe and hold lengths, and optionally auto-increments the address. After a write it can optionally run JEDEC DQ7 data-polling reads, bounded by a timeout, and reports completion through a busy/done handshake.

## Interface
- AW, 19: memory address width, 1..32.
- DW, 8: memory data width, 8 or 16.
- TSU, 1: setup cycles (CS low, address/data stable) before strobe, ≥1.
- TPW, 4: OE_n/WE_n low cycles, ≥1.
- THD, 1: hold cycles after strobe release, ≥1.
- POLL_MAX, 65535: maximum number of poll reads per write, ≥1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_addr  in  1  one-cycle pulse; load the next address byte from wr_buffer[7:0].
- wr_data  in  1  one-cycle pulse; start a write cycle with wr_buffer.
- rd_data  in  1  one-cycle pulse; start a read cycle.
- wr_buffer  in  DW  address byte (bits 7:0) or write data.
- autoinc_ena  in  1  increment next_addr on each accepted rd/wr.
- poll_ena  in  1  sampled at write accept; enables DQ7 polling after the write.
- rd_buffer  out  DW  last captured read data.
- busy  out  1  cycle in progress.
- done  out  1  one-cycle pulse when a command completes.
- timeout  out  1  sticky; polling hit POLL_MAX.
- rom_a  out  AW  address; tri-stated while in reset.
- rom_d  inout  DW  data; driven only during write cycles.
- rom_cs_n, rom_oe_n, rom_we_n  out  1 each  memory strobes, registered.

## Operation
- Reset values: rd_buffer=0, busy=0, done=0, timeout=0, rom_cs_n=rom_oe_n=rom_we_n=1, rom_d=Z, rom_a=Z, next_addr=0, address byte phase=0. rom_a is driven from the first clk edge after rst_n rises.
- Address load: NAB=ceil(AW/8) bytes, least significant byte first. Each wr_addr writes byte[phase], and phase advances modulo NAB. Bits of the top byte above AW are discarded. An accepted rd/wr resets phase to 0.
- A command is accepted only when busy=0. The accept cycle may coincide with done.
- Commands arriving while busy=1 are ignored and change no state.
- A cycle with two or more of wr_addr/wr_data/rd_data high is ignored entirely.
- At rd/wr accept: addr←next_addr, rnw←rd_data, write data latched, poll flag←poll_ena&wr_data, timeout←0. If autoinc_ena, next_addr increments modulo 2^AW.
- FSM states: IDLE → SETUP(TSU) → STROBE(TPW) → HOLD(THD) → IDLE, or → SETUP for a poll read.
  - SETUP: cs_n=0; for writes, rom_d is driven.
  - STROBE: cs_n=0; oe_n=0 for reads, we_n=0 for writes.
  - HOLD: strobes high, cs_n=0; write data still driven.
- Data drive window: rom_d is driven from the first SETUP cycle through the last HOLD cycle of write cycles only.
- Read capture: rd_buffer←rom_d on the clock edge that ends the last STROBE cycle.
- Polling: after the write HOLD with the poll flag set, the controller runs read cycles at the same address with the same timing.
  - After each poll read HOLD: if captured bit 7 equals the written bit 7, go to IDLE.
  - Otherwise, if POLL_MAX poll reads are done, go to IDLE with timeout=1.
  - Otherwise, run another poll read.
- done pulses in the first IDLE cycle after any completed command (plain or polled).
- Mid-operation reset: all outputs return to reset values immediately (asynchronously). No partial strobe is extended.

## Timing
- Plain command accepted at edge N: busy=1 for TSU+TPW+THD cycles starting at N+1. done=1 and busy=0 in the following cycle. With defaults, done is high in cycle N+7.
- rom_a changes only at accept, never during SETUP, STROBE or HOLD.
- Write-to-poll turnaround: rom_d releases at the start of poll SETUP, and oe_n falls TSU (≥1) cycles later. Bus contention is therefore impossible.
- Polled write latency: (1+k)·(TSU+TPW+THD) busy cycles for k poll reads, 1≤k≤POLL_MAX.
- Counters are sized from max(TSU,TPW,THD) and POLL_MAX. No arithmetic overflow is permitted.

## Test plan
- wr_addr 0x34, 0x12, 0xFF, then rd_data; memory model drives 0xA5 → rom_a=0x71234, oe_n low 4 cycles, rd_buffer=0xA5, done at N+7.
- autoinc_ena=1; wr_data 0x11, 0x22, 0x33, each issued in its done cycle → writes at 0x71234/5/6; we_n low 4 cycles each; rom_d Z outside SETUP..HOLD.
- next_addr=0x7FFFF, autoinc_ena=1, two reads → rom_a 0x7FFFF then 0x00000.
- poll_ena=1, write 0x80, model returns 0x00 three times then 0x80 → four poll reads, timeout=0, rd_buffer=0x80. With POLL_MAX=4 and a model that always returns 0x00 → four poll reads, then done with timeout=1.
- rd_data during busy → ignored. wr_addr and rd_data in the same cycle → ignored, phase unchanged.
- rst_n low mid-STROBE of a write → we_n=1, cs_n=1, rom_d=Z, rom_a=Z without waiting for a clock edge.
